mem_wb_stage: RTL and testbench

//  MEM/WB pipeline register of the 5-stage MIPS core. It captures the MEM-stage

---
 rtl/mem_wb_stage.sv | 106 ++++++++++
 tb/tb_mem_wb_stage.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline register with load alignment and writeback select
module mem_wb_stage #(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                flush,
  input  logic                in_valid,
  input  logic                reg_write_in,
  input  logic                mem_to_reg_in,
  input  logic [4:0]          dst_in,
  input  logic [31:0]         alu_result_in,
  input  logic [31:0]         load_data_in,
  input  logic [1:0]          load_size,
  input  logic                load_unsigned,
  output logic [31:0]         mem_wb_data,
  output logic [4:0]          mem_wb_dst,
  output logic                mem_wb_reg_write,
  output logic                mem_wb_valid,
  output logic [RETIRE_W-1:0] retired
);

  logic [31:0]         data_q, data_d;
  logic [4:0]          dst_q, dst_d;
  logic                reg_write_q, reg_write_d;
  logic                valid_q, valid_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;

  logic [1:0]  off;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] aligned;
  logic [31:0] wb_val;
  logic        writes;

  assign off = alu_result_in[1:0];

  // Big-endian lane select: offset 0 is the most significant byte.
  always_comb begin
    load_byte = 8'h00;
    case (off)
      2'd0:    load_byte = load_data_in[31:24];
      2'd1:    load_byte = load_data_in[23:16];
      2'd2:    load_byte = load_data_in[15:8];
      default: load_byte = load_data_in[7:0];
    endcase
    load_half = off[1] ? load_data_in[15:0] : load_data_in[31:16];
  end

  always_comb begin
    aligned = load_data_in;
    case (load_size)
      2'b00:   aligned = {{24{~load_unsigned & load_byte[7]}}, load_byte};
      2'b01:   aligned = {{16{~load_unsigned & load_half[15]}}, load_half};
      default: aligned = load_data_in;
    endcase
  end

  assign wb_val = mem_to_reg_in ? aligned : alu_result_in;
  // Forwarding compares against dst without a write-enable, so non-writers must show dst=0.
  assign writes = in_valid & reg_write_in & (dst_in != 5'd0);

  always_comb begin
    data_d      = data_q;
    dst_d       = dst_q;
    reg_write_d = reg_write_q;
    valid_d     = valid_q;
    retired_d   = retired_q;
    if (flush) begin
      data_d      = 32'h0;
      dst_d       = 5'd0;
      reg_write_d = 1'b0;
      valid_d     = 1'b0;
    end else if (!stall) begin
      valid_d     = in_valid;
      reg_write_d = writes;
      dst_d       = writes ? dst_in : 5'd0;
      data_d      = writes ? wb_val : 32'h0;
      retired_d   = retired_q + RETIRE_W'(in_valid);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q      <= 32'h0;
      dst_q       <= 5'd0;
      reg_write_q <= 1'b0;
      valid_q     <= 1'b0;
      retired_q   <= '0;
    end else begin
      data_q      <= data_d;
      dst_q       <= dst_d;
      reg_write_q <= reg_write_d;
      valid_q     <= valid_d;
      retired_q   <= retired_d;
    end
  end

  assign mem_wb_data      = data_q;
  assign mem_wb_dst       = dst_q;
  assign mem_wb_reg_write = reg_write_q;
  assign mem_wb_valid     = valid_q;
  assign retired          = retired_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - randomized bench for mem_wb_stage against a reference model
module tb_mem_wb_stage;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst, stall, flush, in_valid, reg_write_in, mem_to_reg_in, load_unsigned;
  logic [4:0]    dst_in;
  logic [31:0]   alu_result_in, load_data_in;
  logic [1:0]    load_size;
  logic [31:0]   mem_wb_data;
  logic [4:0]    mem_wb_dst;
  logic          mem_wb_reg_write, mem_wb_valid;
  logic [RW-1:0] retired;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] m_data;
  logic [4:0]  m_dst;
  logic        m_rw, m_valid;
  int          m_ret;

  always #5 clk = ~clk;

  mem_wb_stage #(.RETIRE_W(RW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in), .dst_in(dst_in),
    .alu_result_in(alu_result_in), .load_data_in(load_data_in), .load_size(load_size),
    .load_unsigned(load_unsigned), .mem_wb_data(mem_wb_data), .mem_wb_dst(mem_wb_dst),
    .mem_wb_reg_write(mem_wb_reg_write), .mem_wb_valid(mem_wb_valid), .retired(retired)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] ref_wb();
    int unsigned off, v;
    off = alu_result_in % 4;
    if (!mem_to_reg_in) return alu_result_in;
    if (load_size == 2'b00) begin
      v = (load_data_in >> (8 * (3 - off))) & 32'hFF;
      if (!load_unsigned && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (load_size == 2'b01) begin
      v = (load_data_in >> ((off >= 2) ? 0 : 16)) & 32'hFFFF;
      if (!load_unsigned && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = load_data_in;
    end
    return v;
  endfunction

  task automatic model_edge();
    bit wr;
    if (rst) begin
      m_data = 0; m_dst = 0; m_rw = 0; m_valid = 0; m_ret = 0;
    end else if (flush) begin
      m_data = 0; m_dst = 0; m_rw = 0; m_valid = 0;
    end else if (!stall) begin
      wr      = in_valid && reg_write_in && dst_in != 0;
      m_valid = in_valid;
      m_rw    = wr;
      m_dst   = wr ? dst_in : 5'd0;
      m_data  = wr ? ref_wb() : 32'h0;
      if (in_valid) m_ret = (m_ret + 1) % (1 << RW);
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check({tag, ".data"}, mem_wb_data, m_data);
    check({tag, ".dst"}, 32'(mem_wb_dst), 32'(m_dst));
    check({tag, ".rw"}, 32'(mem_wb_reg_write), 32'(m_rw));
    check({tag, ".valid"}, 32'(mem_wb_valid), 32'(m_valid));
    check({tag, ".ret"}, 32'(retired), 32'(m_ret));
  endtask

  task automatic rand_inputs();
    in_valid      = ($urandom_range(3) != 0);
    reg_write_in  = ($urandom_range(3) != 0);
    mem_to_reg_in = $urandom_range(1);
    dst_in        = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom);
    alu_result_in = $urandom;
    load_data_in  = $urandom;
    load_size     = 2'($urandom);
    load_unsigned = $urandom_range(1);
  endtask

  task automatic set_in(input logic v, input logic rw, input logic m2r, input logic [4:0] d,
                        input logic [31:0] alu, input logic [31:0] ld, input logic [1:0] sz,
                        input logic uns);
    in_valid = v; reg_write_in = rw; mem_to_reg_in = m2r; dst_in = d;
    alu_result_in = alu; load_data_in = ld; load_size = sz; load_unsigned = uns;
  endtask

  initial begin
    m_data = 0; m_dst = 0; m_rw = 0; m_valid = 0; m_ret = 0;
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    rand_inputs();
    tick("rst0");
    rand_inputs();
    tick("rst1");
    check("rst.data0", mem_wb_data, 32'h0);
    check("rst.ret0", 32'(retired), 32'h0);
    rst = 1'b0;

    set_in(1, 1, 0, 5'd5, 32'h1234_5678, 32'h0, 2'b10, 0);
    tick("alu");
    check("alu.data", mem_wb_data, 32'h1234_5678);
    check("alu.dst", 32'(mem_wb_dst), 32'd5);
    check("alu.ret", 32'(retired), 32'd1);

    set_in(1, 1, 1, 5'd3, 32'h0000_1001, 32'h1180_2233, 2'b00, 0);
    tick("lb");
    check("lb.data", mem_wb_data, 32'hFFFF_FF80);
    load_unsigned = 1'b1;
    tick("lbu");
    check("lbu.data", mem_wb_data, 32'h0000_0080);
    set_in(1, 1, 1, 5'd4, 32'h0000_0002, 32'h0000_8001, 2'b01, 0);
    tick("lh");
    check("lh.data", mem_wb_data, 32'hFFFF_8001);

    set_in(1, 1, 0, 5'd0, 32'hDEAD_BEEF, 32'h0, 2'b10, 0);
    tick("dst0");
    check("dst0.data", mem_wb_data, 32'h0);
    check("dst0.valid", 32'(mem_wb_valid), 32'd1);
    check("dst0.ret", 32'(retired), 32'd5);

    set_in(1, 1, 0, 5'd9, 32'hA5A5_0001, 32'h0, 2'b10, 0);
    tick("instA");
    set_in(1, 1, 0, 5'd10, 32'hB0B0_0002, 32'h0, 2'b10, 0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) tick("stall");
    check("stall.data", mem_wb_data, 32'hA5A5_0001);
    check("stall.dst", 32'(mem_wb_dst), 32'd9);
    check("stall.ret", 32'(retired), 32'd6);
    flush = 1'b1;
    tick("stflush");
    check("stflush.valid", 32'(mem_wb_valid), 32'd0);
    check("stflush.ret", 32'(retired), 32'd6);
    stall = 1'b0; flush = 1'b0;

    rst = 1'b1;
    tick("wraprst");
    rst = 1'b0;
    set_in(1, 1, 0, 5'd7, 32'h0, 32'h0, 2'b10, 0);
    for (int i = 0; i < 15; i++) tick("wrap");
    check("wrap.ret15", 32'(retired), 32'd15);
    tick("wrap16");
    check("wrap.ret0", 32'(retired), 32'd0);
    tick("wrap17");
    stall = 1'b1; rst = 1'b1;
    tick("rststall");
    check("rststall.dst", 32'(mem_wb_dst), 32'd0);
    check("rststall.valid", 32'(mem_wb_valid), 32'd0);
    rst = 1'b0; stall = 1'b0;

    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      rst   = ($urandom_range(39) == 0);
      flush = ($urandom_range(7) == 0);
      stall = ($urandom_range(4) == 0);
      tick("rnd");
      if (mem_wb_dst == 5'd0) begin
        check("inv.data", mem_wb_data, 32'h0);
        check("inv.rw", 32'(mem_wb_reg_write), 32'd0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
